// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, state encodings and the parity helper for the
//               UART transmit scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default serial frame length: start + 8 data + parity + stop
  localparam int FRAME_CYCLES_DEF = 11;

  // Scheduler state encodings
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PUSH     = 3'd1;
  localparam logic [2:0] ST_PUSH_END = 3'd2;
  localparam logic [2:0] ST_TX       = 3'd3;
  localparam logic [2:0] ST_TX_END   = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    PUSH     = ST_PUSH,
    PUSH_END = ST_PUSH_END,
    TX       = ST_TX,
    TX_END   = ST_TX_END
  } state_t;

  // Parity bit for one byte; forced low when parity is disabled
  function automatic logic calc_parity(input logic [7:0] data,
                                       input logic       en,
                                       input logic       odd);
    logic p;
    p = odd ? ~^data : ^data;
    return en ? p : 1'b0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched_if
// Description : Requester and transmit-FIFO handshake bundle for the UART
//               transmit scheduler. master = scheduler, slave = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 2
);
  // Requester side
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  // FIFO side
  logic                 ff_start_rx;
  logic [7:0]           ff_data;
  logic                 ff_parity;
  logic                 ff_pready_w;
  logic                 ff_full;
  logic                 ff_start_tx_n;
  logic                 ff_new_instr;
  logic                 rx_ready;

  modport master (
    input  req_valid, req_data, ff_pready_w, ff_full, rx_ready,
    output req_ack, ff_start_rx, ff_data, ff_parity, ff_start_tx_n, ff_new_instr
  );

  modport slave (
    output req_valid, req_data, ff_pready_w, ff_full, rx_ready,
    input  req_ack, ff_start_rx, ff_data, ff_parity, ff_start_tx_n, ff_new_instr
  );
endinterface
`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_arbiter
// Description : Combinational round-robin arbiter. Grants the lowest-index
//               active request at or above the pointer, wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int c;

  // Scan requesters starting at the pointer; the first active one wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = c[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched
// Description : Round-robin scheduler in front of the UART transmit FIFO.
//               Arbitrates byte pushes, computes parity, and starts serial
//               transmission on a fill threshold or an idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int PUSH_TIMEOUT = 8
) (
  input  logic                   baud_clk,
  input  logic                   rst,
  uart_tx_sched_if.master        bus,
  input  logic                   cfg_parity_en,
  input  logic                   cfg_parity_odd,
  input  logic [4:0]             cfg_threshold,
  input  logic [7:0]             cfg_timeout,
  output logic [4:0]             pending_cnt,
  output logic                   busy,
  output logic                   push_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int FC_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int WC_W  = $clog2(PUSH_TIMEOUT + 1);

  localparam logic [4:0]       DEPTH_C    = 5'(FIFO_DEPTH);
  localparam logic [FC_W-1:0]  FRAME_LAST = FC_W'(FRAME_CYCLES - 1);
  localparam logic [WC_W-1:0]  WAIT_LAST  = WC_W'(PUSH_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_REQ - 1);

  state_t            state_q,       state_d;
  logic [IDX_W-1:0]  grant_idx_q,   grant_idx_d;
  logic [IDX_W-1:0]  rr_ptr_q,      rr_ptr_d;
  logic [7:0]        ff_data_q,     ff_data_d;
  logic              ff_parity_q,   ff_parity_d;
  logic [7:0]        idle_cnt_q,    idle_cnt_d;
  logic [FC_W-1:0]   frame_cnt_q,   frame_cnt_d;
  logic [4:0]        pending_cnt_q, pending_cnt_d;
  logic [WC_W-1:0]   wait_cnt_q,    wait_cnt_d;
  logic              push_err_q,    push_err_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [7:0]         sel_data;
  logic [4:0]         thr_eff;
  logic               tx_trig;
  logic               push_ok;
  logic               ack_pulse;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // AND-OR select of the granted requester's byte
  always_comb begin
    sel_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) sel_data = sel_data | bus.req_data[8*i +: 8];
    end
  end

  // A threshold of zero behaves like one so a single byte can still trigger
  assign thr_eff = (cfg_threshold == 5'd0) ? 5'd1 : cfg_threshold;
  assign tx_trig = (pending_cnt_q >= thr_eff) ||
                   ((cfg_timeout != 8'd0) && (pending_cnt_q != 5'd0) &&
                    (idle_cnt_q == cfg_timeout));
  assign push_ok = arb_any && !bus.ff_full && (pending_cnt_q < DEPTH_C);

  // Next-state, counter and datapath decisions
  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    rr_ptr_d      = rr_ptr_q;
    ff_data_d     = ff_data_q;
    ff_parity_d   = ff_parity_q;
    idle_cnt_d    = idle_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    pending_cnt_d = pending_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    push_err_d    = push_err_q;
    ack_pulse     = 1'b0;

    case (state_q)
      IDLE: begin
        // Transmit has priority over a simultaneous push request
        if (tx_trig && bus.rx_ready) begin
          state_d     = TX;
          idle_cnt_d  = 8'd0;
          frame_cnt_d = '0;
        end else if (push_ok) begin
          state_d     = PUSH;
          grant_idx_d = arb_idx;
          rr_ptr_d    = (arb_idx == IDX_LAST) ? '0 : arb_idx + 1'b1;
          ff_data_d   = sel_data;
          ff_parity_d = calc_parity(sel_data, cfg_parity_en, cfg_parity_odd);
          idle_cnt_d  = 8'd0;
          wait_cnt_d  = '0;
        end else if ((pending_cnt_q != 5'd0) && (idle_cnt_q != 8'hFF)) begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end

      PUSH: begin
        if (bus.ff_pready_w) begin
          ack_pulse     = 1'b1;
          pending_cnt_d = pending_cnt_q + 5'd1;
          state_d       = PUSH_END;
        end else if (wait_cnt_q == WAIT_LAST) begin
          push_err_d = 1'b1;
          state_d    = PUSH_END;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      // Strobe low for one cycle lets the FIFO fall back to its wait state
      PUSH_END: state_d = IDLE;

      TX: begin
        if (frame_cnt_q == FRAME_LAST) begin
          frame_cnt_d   = '0;
          pending_cnt_d = pending_cnt_q - 5'd1;
          if ((pending_cnt_q == 5'd1) || !bus.rx_ready) state_d = TX_END;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end

      TX_END: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      grant_idx_q   <= '0;
      rr_ptr_q      <= '0;
      ff_data_q     <= 8'h00;
      ff_parity_q   <= 1'b0;
      idle_cnt_q    <= 8'd0;
      frame_cnt_q   <= '0;
      pending_cnt_q <= 5'd0;
      wait_cnt_q    <= '0;
      push_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      rr_ptr_q      <= rr_ptr_d;
      ff_data_q     <= ff_data_d;
      ff_parity_q   <= ff_parity_d;
      idle_cnt_q    <= idle_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      pending_cnt_q <= pending_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      push_err_q    <= push_err_d;
    end
  end

  // Acknowledge only the granted requester, in the cycle the FIFO stores
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ack
    assign bus.req_ack[i] = ack_pulse && (grant_idx_q == IDX_W'(i));
  end

  assign bus.ff_start_rx   = (state_q == PUSH);
  assign bus.ff_data       = ff_data_q;
  assign bus.ff_parity     = ff_parity_q;
  assign bus.ff_start_tx_n = (state_q != TX);
  assign bus.ff_new_instr  = (state_q == TX_END);

  assign pending_cnt = pending_cnt_q;
  assign busy        = (state_q != IDLE);
  assign push_err    = push_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_sched
// Description : Self-checking bench for uart_tx_sched: table of push vectors
//               plus directed sequences for arbitration, transmit triggers,
//               backpressure, push timeout and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

  localparam int NR = 2;

  logic       clk;
  logic       rst;
  logic       cfg_parity_en;
  logic       cfg_parity_odd;
  logic [4:0] cfg_threshold;
  logic [7:0] cfg_timeout;
  logic [4:0] pending_cnt;
  logic       busy;
  logic       push_err;
  logic       pready;
  logic       pready_en;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_sched_if #(.NUM_REQ(NR)) bus ();

  uart_tx_sched #(
    .NUM_REQ      (NR),
    .FIFO_DEPTH   (16),
    .FRAME_CYCLES (11),
    .PUSH_TIMEOUT (8)
  ) dut (
    .baud_clk       (clk),
    .rst            (rst),
    .bus            (bus),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_threshold  (cfg_threshold),
    .cfg_timeout    (cfg_timeout),
    .pending_cnt    (pending_cnt),
    .busy           (busy),
    .push_err       (push_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: stores the byte one cycle after the receive strobe rises
  always @(posedge clk or negedge rst) begin
    if (!rst) pready <= 1'b0;
    else      pready <= pready_en && bus.ff_start_rx && !pready;
  end
  assign bus.ff_pready_w = pready;

  typedef struct {
    logic [1:0] vld;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       pen;
    logic       podd;
    logic [1:0] exp_ack;
    logic [7:0] exp_data;
    logic       exp_par;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.ff_full    = 1'b0;
    bus.rx_ready   = 1'b0;
    pready_en      = 1'b1;
    cfg_parity_en  = 1'b1;
    cfg_parity_odd = 1'b0;
    cfg_threshold  = 5'd31;
    cfg_timeout    = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Waits (bounded) for any ack; returns at the negedge it was seen
  task automatic wait_ack(output logic [NR-1:0] ackv, output logic got);
    got  = 1'b0;
    ackv = '0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (bus.req_ack != '0) begin
        got  = 1'b1;
        ackv = bus.req_ack;
      end
    end
  endtask

  task automatic push_one(input logic [7:0] d);
    logic [NR-1:0] ackv;
    logic          got;
    bus.req_data[7:0] = d;
    bus.req_valid     = 2'b01;
    wait_ack(ackv, got);
    bus.req_valid     = 2'b00;
    check("push_one_ack", {31'd0, got}, 32'd1);
  endtask

  // From the ack negedge: latency to transmit start, frame length, pending steps
  task automatic run_tx(input int exp_start_pend, output int lat, output int low_len);
    lat     = 0;
    low_len = 0;
    while (bus.ff_start_tx_n && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    while (!bus.ff_start_tx_n && low_len < 100) begin
      if (low_len % 11 == 0)
        check("tx_pending_step", {27'd0, pending_cnt}, exp_start_pend - low_len / 11);
      @(negedge clk);
      low_len++;
    end
  endtask

  initial begin
    logic [NR-1:0] ackv;
    logic          got;
    int            lat, low_len, cnt0, cnt1, rx_cycles;
    logic          saw_ack, saw_rx;

    //            vld    d0     d1     pen   podd  ack    data   par
    vecs[0] = '{2'b01, 8'hA5, 8'h00, 1'b1, 1'b0, 2'b01, 8'hA5, 1'b0};
    vecs[1] = '{2'b01, 8'h3C, 8'h00, 1'b1, 1'b1, 2'b01, 8'h3C, 1'b1};
    vecs[2] = '{2'b10, 8'h00, 8'h07, 1'b1, 1'b0, 2'b10, 8'h07, 1'b1};
    vecs[3] = '{2'b11, 8'hFF, 8'h80, 1'b0, 1'b0, 2'b01, 8'hFF, 1'b0};
    vecs[4] = '{2'b11, 8'h01, 8'h80, 1'b1, 1'b1, 2'b10, 8'h80, 1'b0};
    vecs[5] = '{2'b10, 8'h00, 8'h00, 1'b1, 1'b1, 2'b10, 8'h00, 1'b1};

    // ---------------- reset values ----------------
    rst            = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.ff_full    = 1'b0;
    bus.rx_ready   = 1'b0;
    pready_en      = 1'b1;
    cfg_parity_en  = 1'b1;
    cfg_parity_odd = 1'b0;
    cfg_threshold  = 5'd31;
    cfg_timeout    = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_req_ack",    {30'd0, bus.req_ack}, 32'd0);
    check("rst_start_rx",   {31'd0, bus.ff_start_rx}, 32'd0);
    check("rst_ff_data",    {24'd0, bus.ff_data}, 32'd0);
    check("rst_ff_parity",  {31'd0, bus.ff_parity}, 32'd0);
    check("rst_start_tx_n", {31'd0, bus.ff_start_tx_n}, 32'd1);
    check("rst_new_instr",  {31'd0, bus.ff_new_instr}, 32'd0);
    check("rst_pending",    {27'd0, pending_cnt}, 32'd0);
    check("rst_busy",       {31'd0, busy}, 32'd0);
    check("rst_push_err",   {31'd0, push_err}, 32'd0);

    // ---------------- push table ----------------
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cfg_parity_en  = vecs[i].pen;
      cfg_parity_odd = vecs[i].podd;
      bus.req_data   = {vecs[i].d1, vecs[i].d0};
      bus.req_valid  = vecs[i].vld;
      wait_ack(ackv, got);
      check("tbl_ack_seen", {31'd0, got}, 32'd1);
      check("tbl_ack",      {30'd0, ackv}, {30'd0, vecs[i].exp_ack});
      check("tbl_data",     {24'd0, bus.ff_data}, {24'd0, vecs[i].exp_data});
      check("tbl_parity",   {31'd0, bus.ff_parity}, {31'd0, vecs[i].exp_par});
      bus.req_valid = '0;
      @(negedge clk);
      check("tbl_ack_pulse",    {30'd0, bus.req_ack}, 32'd0);
      check("tbl_start_rx_low", {31'd0, bus.ff_start_rx}, 32'd0);
      check("tbl_pending",      {27'd0, pending_cnt}, i + 1);
      @(negedge clk);
      check("tbl_idle", {31'd0, busy}, 32'd0);
    end

    // ---------------- round robin ----------------
    do_reset();
    bus.req_data  = {8'h22, 8'h11};
    bus.req_valid = 2'b11;
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(ackv, got);
      check("rr_ack",  {30'd0, ackv}, (k % 2 == 0) ? 32'd1 : 32'd2);
      check("rr_data", {24'd0, bus.ff_data}, (k % 2 == 0) ? 32'h11 : 32'h22);
      if (ackv[0]) cnt0++;
      if (ackv[1]) cnt1++;
    end
    bus.req_valid = '0;
    check("rr_cnt0", cnt0, 32'd2);
    check("rr_cnt1", cnt1, 32'd2);

    // ---------------- threshold transmit ----------------
    do_reset();
    cfg_threshold = 5'd3;
    bus.rx_ready  = 1'b1;
    push_one(8'h41);
    repeat (2) @(negedge clk);
    push_one(8'h42);
    repeat (2) @(negedge clk);
    push_one(8'h43);
    run_tx(3, lat, low_len);
    check("thr_latency", lat, 32'd3);
    check("thr_tx_len",  low_len, 32'd33);
    check("thr_new_instr", {31'd0, bus.ff_new_instr}, 32'd1);
    check("thr_pending_end", {27'd0, pending_cnt}, 32'd0);
    @(negedge clk);
    check("thr_new_instr_off", {31'd0, bus.ff_new_instr}, 32'd0);
    check("thr_idle", {31'd0, busy}, 32'd0);

    // ---------------- timeout transmit ----------------
    do_reset();
    cfg_threshold = 5'd8;
    cfg_timeout   = 8'd5;
    bus.rx_ready  = 1'b1;
    push_one(8'h5A);
    run_tx(1, lat, low_len);
    check("to_latency", lat, 32'd8);
    check("to_tx_len",  low_len, 32'd11);
    check("to_pending_end", {27'd0, pending_cnt}, 32'd0);

    // ---------------- FIFO full backpressure ----------------
    do_reset();
    bus.ff_full       = 1'b1;
    bus.req_data[7:0] = 8'h99;
    bus.req_valid     = 2'b01;
    saw_ack = 1'b0;
    saw_rx  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.req_ack != '0) saw_ack = 1'b1;
      if (bus.ff_start_rx)   saw_rx  = 1'b1;
    end
    check("full_no_start_rx", {31'd0, saw_rx}, 32'd0);
    check("full_no_ack",      {31'd0, saw_ack}, 32'd0);
    check("full_not_busy",    {31'd0, busy}, 32'd0);
    bus.ff_full = 1'b0;
    wait_ack(ackv, got);
    bus.req_valid = '0;
    check("full_release_ack", {31'd0, got}, 32'd1);

    // ---------------- push timeout ----------------
    do_reset();
    pready_en         = 1'b0;
    bus.req_data[7:0] = 8'h77;
    bus.req_valid     = 2'b01;
    saw_ack   = 1'b0;
    rx_cycles = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.req_ack != '0) saw_ack = 1'b1;
      if (bus.ff_start_rx) rx_cycles++;
      else if (rx_cycles != 0) break;
    end
    bus.req_valid = '0;
    check("pto_wait_cycles", rx_cycles, 32'd8);
    check("pto_push_err",    {31'd0, push_err}, 32'd1);
    check("pto_no_ack",      {31'd0, saw_ack}, 32'd0);
    check("pto_pending",     {27'd0, pending_cnt}, 32'd0);
    repeat (3) @(negedge clk);
    check("pto_err_sticky",  {31'd0, push_err}, 32'd1);

    // ---------------- asynchronous reset mid-frame ----------------
    do_reset();
    cfg_threshold = 5'd1;
    bus.rx_ready  = 1'b1;
    push_one(8'h12);
    lat = 0;
    while (bus.ff_start_tx_n && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("arst_tx_started", {31'd0, bus.ff_start_tx_n}, 32'd0);
    repeat (5) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("arst_start_tx_n", {31'd0, bus.ff_start_tx_n}, 32'd1);
    check("arst_pending",    {27'd0, pending_cnt}, 32'd0);
    check("arst_busy",       {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
